i2c_reg_slave: RTL and testbench
================================

I2C_REG_SLAVE -- requirements
Module: i2c_reg_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h60, the 7-bit bus address the block answers to.
REQ-002 SHALL have parameter NUM_REGS, default 16, the register file depth (2..256).
REQ-003 SHALL have parameter RESET_VAL, default 8'hEC, the reset content of every register.
REQ-004 SHALL have parameter AUTO_INC, default 1, which enables register pointer post-increment after each data byte.
REQ-005 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-007 SHALL have port scl, input, 1, the I2C serial clock (block never stretches).
REQ-008 SHALL have port sda, inout, 1, the I2C data line, driven only to 0 or Z.
REQ-009 SHALL have port busy, output, 1, high from an addressed START until STOP or a not-addressed condition.
REQ-010 SHALL have port wr_pulse, output, 1, a one-clk strobe when a register is written from the bus.
REQ-011 SHALL have port wr_addr, output, 8, the register index written, valid with wr_pulse.
REQ-012 SHALL have port wr_data, output, 8, the data byte written, valid with wr_pulse.

Function
REQ-013 SHALL pass scl and sda through 2-flop synchronisers plus a previous-value flop; edge, START and STOP detection SHALL use only synchronised values.
REQ-014 SHALL detect START as sda 1->0 while scl is high, and STOP as sda 0->1 while scl is high.
REQ-015 SHALL implement the states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK and WAIT_STOP.
REQ-016 SHALL, on START in any state (including repeated START), clear the bit counter, release sda and enter ADDR.
REQ-017 SHALL, on STOP in any state, release sda, deassert busy and enter IDLE.
REQ-018 SHALL sample sda on scl rising edges MSB-first in ADDR, PTR and WR, and change its own sda drive only on scl falling edges.
REQ-019 SHALL, in ADDR after 8 bits, ACK (drive 0 for one scl high phase) when the address matches; otherwise it SHALL release sda and enter WAIT_STOP with busy low.
REQ-020 SHALL, on a matched address with R/W=0, proceed to PTR; with R/W=1, proceed to RD using the current pointer.
REQ-021 SHALL load the pointer from the PTR byte and ACK it if the value is below NUM_REGS; otherwise it SHALL NACK, leave the pointer unchanged and enter WAIT_STOP.
REQ-022 SHALL, in WR after 8 bits, write regs[ptr], assert wr_pulse for exactly one clk with wr_addr=ptr and wr_data=byte, ACK the byte, and return to WR for further bytes.
REQ-023 SHALL in RD shift out regs[ptr] MSB-first, then in RD_ACK release sda and sample the master's ACK; ACK (0) SHALL continue with RD, NACK (1) SHALL enter WAIT_STOP.
REQ-024 SHALL, when AUTO_INC=1, increment the pointer after each written or read byte, wrapping from NUM_REGS-1 to 0; when AUTO_INC=0, it SHALL leave the pointer fixed.
REQ-025 SHALL retain the pointer across STOP so that write-pointer, STOP or repeated START, then read works.
REQ-026 SHALL, for a read, present the first data bit on sda before the first scl rising edge after the ADDR_ACK falling edge.
REQ-027 SHALL never drive sda in IDLE or WAIT_STOP, nor during master-driven bits.

Reset
REQ-028 SHALL, while rst_n=0, force state to IDLE, sda to Z, busy/wr_pulse to 0, wr_addr/wr_data to 0, pointer to 0, bit counter to 0, and all registers to RESET_VAL.
REQ-029 SHALL, when reset is asserted mid-transfer, release sda within the same clk and ignore the bus until the next START after deassertion.

Verification
REQ-030 SHALL pass: START, 0xC0, 0x03, 0x5A, STOP -> three ACKs, wr_pulse once with wr_addr=3 and wr_data=0x5A, and regs[3]=0x5A.
REQ-031 SHALL pass: write pointer 0x03, repeated START, 0xC1, read 2 bytes (ACK then NACK) -> sda shows 0x5A then 0xEC, and the pointer ends at 5.
REQ-032 SHALL pass: START, 0xA0 -> no ACK, busy stays 0, sda stays Z until STOP.
REQ-033 SHALL pass: pointer 0x10 with NUM_REGS=16 -> the pointer byte is NACKed and no write occurs.
REQ-034 SHALL pass: write pointer 15, then data 0x11 and 0x22 -> regs[15]=0x11 and regs[0]=0x22 (wrap).
REQ-035 SHALL pass: rst_n pulsed low during a read data bit -> sda is released immediately, all registers return to 0xEC, and the next transaction succeeds.

Source files
------------

// File: rtl/i2c_reg_slave.sv
// I2C register-file slave: 7-bit address, pointer byte, then data bytes.
// Oversamples scl/sda on clk; never stretches the clock.
module i2c_reg_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h60,
    parameter int         NUM_REGS   = 16,
    parameter logic [7:0] RESET_VAL  = 8'hEC,
    parameter bit         AUTO_INC   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    inout  wire        sda,
    output logic       busy,
    output logic       wr_pulse,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data
);
    localparam int PW = $clog2(NUM_REGS);
    localparam logic [8:0] NREG9 = 9'(NUM_REGS);
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REGS - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
        WR, WR_ACK, RD, RD_ACK, WAIT_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [PW-1:0] ptr_q, ptr_d, ptr_nxt;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          nack_q, nack_d;
    logic          wr_pulse_q, wr_pulse_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    regs_q [NUM_REGS];
    logic [7:0]    regs_d [NUM_REGS];

    logic scl_s1_q, scl_s2_q, scl_p_q;
    logic sda_s1_q, sda_s2_q, sda_p_q;

    // Open-drain output: only ever pull low or release
    assign sda      = sda_oe_q ? 1'b0 : 1'bz;
    assign busy     = busy_q;
    assign wr_pulse = wr_pulse_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

    // Two-flop synchronisers plus previous-value flops; idle bus is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_p_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_p_q  <= 1'b1;
        end else begin
            scl_s1_q <= scl;
            scl_s2_q <= scl_s1_q;
            scl_p_q  <= scl_s2_q;
            sda_s1_q <= sda;
            sda_s2_q <= sda_s1_q;
            sda_p_q  <= sda_s2_q;
        end
    end

    logic scl_rise, scl_fall, start_c, stop_c;
    logic addr_hit, ptr_ok, rx_shift, rx_done;

    assign scl_rise = scl_s2_q & ~scl_p_q;
    assign scl_fall = ~scl_s2_q & scl_p_q;
    assign start_c  = scl_s2_q & scl_p_q & sda_p_q & ~sda_s2_q;
    assign stop_c   = scl_s2_q & scl_p_q & ~sda_p_q & sda_s2_q;
    assign addr_hit = (shreg_q[7:1] == SLAVE_ADDR);
    assign ptr_ok   = ({1'b0, shreg_q} < NREG9);
    assign rx_shift = scl_rise && (bit_cnt_q != 4'd8);
    assign rx_done  = scl_fall && (bit_cnt_q == 4'd8);
    assign ptr_nxt  = !AUTO_INC ? ptr_q :
                      (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;

    // Next-state, shift register, pointer, register-file and sda drive
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        ptr_d      = ptr_q;
        sda_oe_d   = sda_oe_q;
        busy_d     = busy_q;
        nack_d     = nack_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        regs_d     = regs_q;
        if (start_c) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop_c) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            unique case (state_q)
                ADDR, PTR, WR: begin
                    if (rx_shift) begin
                        shreg_d   = {shreg_q[6:0], sda_s2_q};
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end else if (rx_done) begin
                        bit_cnt_d = '0;
                        if (state_q == ADDR) begin
                            if (addr_hit) begin
                                sda_oe_d = 1'b1;
                                busy_d   = 1'b1;
                                state_d  = ADDR_ACK;
                            end else begin
                                busy_d  = 1'b0;
                                state_d = WAIT_STOP;
                            end
                        end else if (state_q == PTR) begin
                            if (ptr_ok) begin
                                ptr_d    = shreg_q[PW-1:0];
                                sda_oe_d = 1'b1;
                                state_d  = PTR_ACK;
                            end else begin
                                state_d = WAIT_STOP;
                            end
                        end else begin
                            regs_d[ptr_q] = shreg_q;
                            wr_pulse_d    = 1'b1;
                            wr_addr_d     = 8'(ptr_q);
                            wr_data_d     = shreg_q;
                            ptr_d         = ptr_nxt;
                            sda_oe_d      = 1'b1;
                            state_d       = WR_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = '0;
                        if (shreg_q[0]) begin
                            // First read bit goes out on the ACK falling edge
                            shreg_d  = regs_q[ptr_q];
                            sda_oe_d = ~regs_q[ptr_q][7];
                            state_d  = RD;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = PTR;
                        end
                    end
                end
                PTR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = WR;
                    end
                end
                RD: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            ptr_d     = ptr_nxt;
                            state_d   = RD_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            shreg_d   = {shreg_q[6:0], 1'b0};
                            sda_oe_d  = ~shreg_q[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        nack_d = sda_s2_q;
                    end else if (scl_fall) begin
                        if (nack_q) begin
                            state_d = WAIT_STOP;
                        end else begin
                            shreg_d  = regs_q[ptr_q];
                            sda_oe_d = ~regs_q[ptr_q][7];
                            state_d  = RD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            ptr_q      <= '0;
            sda_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            nack_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            ptr_q      <= ptr_d;
            sda_oe_q   <= sda_oe_d;
            busy_q     <= busy_d;
            nack_q     <= nack_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            regs_q     <= regs_d;
        end
    end
endmodule

// File: tb/tb_i2c_reg_slave.sv
// Bench for i2c_reg_slave: bit-banged master, write scoreboard,
// read-back of register contents over the bus.
module tb_i2c_reg_slave;
    localparam int Q = 80;

    logic       clk;
    logic       rst_n;
    logic       scl;
    logic       m_sda;
    wire        sda;
    logic       busy;
    logic       wr_pulse;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    int n_chk;
    int n_pass;
    logic [15:0] sb [$];
    logic [15:0] sb_e;

    pullup (sda);
    assign sda = m_sda ? 1'bz : 1'b0;

    i2c_reg_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl      (scl),
        .sda      (sda),
        .busy     (busy),
        .wr_pulse (wr_pulse),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && wr_pulse) begin
            if (sb.size() == 0) begin
                chk("wr_unexp", 16'(sb.size()), 16'd1);
            end else begin
                sb_e = sb.pop_front();
                chk("wr_pulse", {wr_addr, wr_data}, sb_e);
            end
        end
    end

    task automatic i2c_start();
        m_sda = 1'b1; #(Q);
        scl = 1'b1;   #(Q);
        m_sda = 1'b0; #(Q);
        scl = 1'b0;   #(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #(Q);
        scl = 1'b1;   #(Q);
        m_sda = 1'b1; #(Q);
    endtask

    task automatic bit_w(input logic b);
        m_sda = b; #(Q);
        scl = 1'b1; #(2 * Q);
        scl = 1'b0; #(Q);
    endtask

    task automatic bit_r(output logic b);
        m_sda = 1'b1; #(Q);
        scl = 1'b1;   #(Q);
        b = sda;      #(Q);
        scl = 1'b0;   #(Q);
    endtask

    task automatic byte_w(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) bit_w(d[i]);
        bit_r(ack);
    endtask

    task automatic byte_r(output logic [7:0] d, input logic ack);
        logic [7:0] t;
        logic       b;
        for (int i = 7; i >= 0; i--) begin
            bit_r(b);
            t[i] = b;
        end
        d = t;
        bit_w(ack);
    endtask

    logic       ack;
    logic [7:0] rd;

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        scl = 1'b1;
        m_sda = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_wrp", {15'd0, wr_pulse}, 16'd0);
        chk("rst_wr", {wr_addr, wr_data}, 16'h0000);
        chk("rst_sda", {15'd0, sda}, 16'd1);
        rst_n = 1'b1;
        #(4 * Q);

        // Write 0x5A to reg 3
        i2c_start();
        byte_w(8'hC0, ack); chk("t1_aack", {15'd0, ack}, 16'd0);
        chk("t1_busy", {15'd0, busy}, 16'd1);
        byte_w(8'h03, ack); chk("t1_pack", {15'd0, ack}, 16'd0);
        sb.push_back(16'h035A);
        byte_w(8'h5A, ack); chk("t1_dack", {15'd0, ack}, 16'd0);
        i2c_stop();
        #(Q);
        chk("t1_idle", {15'd0, busy}, 16'd0);

        // Write 0x77 to reg 5 (marks where the pointer lands later)
        i2c_start();
        byte_w(8'hC0, ack);
        byte_w(8'h05, ack);
        sb.push_back(16'h0577);
        byte_w(8'h77, ack); chk("t1b_dack", {15'd0, ack}, 16'd0);
        i2c_stop();

        // Pointer 3, repeated START, read two bytes
        i2c_start();
        byte_w(8'hC0, ack);
        byte_w(8'h03, ack);
        i2c_start();
        byte_w(8'hC1, ack); chk("t2_rack", {15'd0, ack}, 16'd0);
        byte_r(rd, 1'b0);   chk("t2_rd0", {8'd0, rd}, 16'h005A);
        byte_r(rd, 1'b1);   chk("t2_rd1", {8'd0, rd}, 16'h00EC);
        i2c_stop();
        // Pointer retained across STOP: must now be 5
        i2c_start();
        byte_w(8'hC1, ack);
        byte_r(rd, 1'b1);   chk("t2_ptr5", {8'd0, rd}, 16'h0077);
        i2c_stop();

        // Foreign address: no ACK, never busy, sda left alone
        i2c_start();
        byte_w(8'hA0, ack); chk("t3_nack", {15'd0, ack}, 16'd1);
        chk("t3_busy", {15'd0, busy}, 16'd0);
        byte_r(rd, 1'b1);   chk("t3_sda", {8'd0, rd}, 16'h00FF);
        chk("t3_busy2", {15'd0, busy}, 16'd0);
        i2c_stop();

        // Out-of-range pointer: NACK and no write
        i2c_start();
        byte_w(8'hC0, ack);
        byte_w(8'h10, ack); chk("t4_pnack", {15'd0, ack}, 16'd1);
        byte_w(8'h99, ack); chk("t4_dnack", {15'd0, ack}, 16'd1);
        i2c_stop();

        // Pointer wrap 15 -> 0
        i2c_start();
        byte_w(8'hC0, ack);
        byte_w(8'h0F, ack);
        sb.push_back(16'h0F11);
        byte_w(8'h11, ack);
        sb.push_back(16'h0022);
        byte_w(8'h22, ack); chk("t5_dack", {15'd0, ack}, 16'd0);
        i2c_stop();
        i2c_start();
        byte_w(8'hC0, ack);
        byte_w(8'h0F, ack);
        i2c_start();
        byte_w(8'hC1, ack);
        byte_r(rd, 1'b0);   chk("t5_r15", {8'd0, rd}, 16'h0011);
        byte_r(rd, 1'b1);   chk("t5_r0", {8'd0, rd}, 16'h0022);
        i2c_stop();

        // Reset during a driven read bit (reg3 MSB is 0)
        i2c_start();
        byte_w(8'hC0, ack);
        byte_w(8'h03, ack);
        i2c_start();
        byte_w(8'hC1, ack);
        m_sda = 1'b1; #(Q);
        scl = 1'b1;   #(Q);
        chk("t6_drive", {15'd0, sda}, 16'd0);
        rst_n = 1'b0;
        #1;
        chk("t6_rel", {15'd0, sda}, 16'd1);
        #(30);
        rst_n = 1'b1;
        #(Q);
        scl = 1'b0; #(Q);
        byte_w(8'hC0, ack); chk("t6_ignore", {15'd0, ack}, 16'd1);
        i2c_stop();
        i2c_start();
        byte_w(8'hC0, ack);
        byte_w(8'h03, ack);
        i2c_start();
        byte_w(8'hC1, ack); chk("t6_rack", {15'd0, ack}, 16'd0);
        byte_r(rd, 1'b1);   chk("t6_r3", {8'd0, rd}, 16'h00EC);
        i2c_stop();
        i2c_start();
        byte_w(8'hC0, ack);
        byte_w(8'h07, ack);
        sb.push_back(16'h0733);
        byte_w(8'h33, ack);
        i2c_stop();
        i2c_start();
        byte_w(8'hC0, ack);
        byte_w(8'h07, ack);
        i2c_start();
        byte_w(8'hC1, ack);
        byte_r(rd, 1'b1);   chk("t6_r7", {8'd0, rd}, 16'h0033);
        i2c_stop();

        #(4 * Q);
        chk("sb_empty", 16'(sb.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
